// File: rtl/ov7670_sccb_config_if.sv
// Bus bundle between the OV7670 SCCB configuration sequencer and its surroundings:
// start/status handshake, table ROM port and the SCCB pins.
interface ov7670_sccb_config_if;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        done;
  logic        sioc;
  logic        siod_o;
  logic        siod_oe;

  modport master (
    input  start, rom_data,
    output rom_addr, busy, done, sioc, siod_o, siod_oe
  );

  modport slave (
    output start, rom_data,
    input  rom_addr, busy, done, sioc, siod_o, siod_oe
  );
endinterface

// File: rtl/ov7670_sccb_config.sv
// Walks a {reg,val} table ROM and issues one 3-phase SCCB write (ID 0x42) per entry.
// Define OV7670_SCCB_DELAY_EN to treat 16'hFFF0 as a DELAY_CYCLES settle-time marker.
module ov7670_sccb_config #(
  parameter int CLK_DIV      = 250,
  parameter int DELAY_CYCLES = 2500000
) (
  input logic                  clk,
  input logic                  rst_n,
  ov7670_sccb_config_if.master bus
);
  // One counter serves the quarter divider, the fetch wait and the settle delay.
  localparam int          CNT_MAX   = (DELAY_CYCLES > CLK_DIV) ? DELAY_CYCLES : CLK_DIV;
  localparam int          CW        = $clog2(CNT_MAX + 1);
  localparam logic [15:0] END_MARK  = 16'hFFFF;
  localparam logic [7:0]  WRITE_ID  = 8'h42;
  localparam logic [4:0]  LAST_BIT  = 5'd26;
`ifdef OV7670_SCCB_DELAY_EN
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;
`endif

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_CHECK, ST_START, ST_SEND, ST_STOP, ST_GAP, ST_DELAY, ST_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    qtr;
  logic [4:0]    bit_idx;
  logic [26:0]   frame;
  logic [7:0]    rom_addr;
  logic          busy, done, sioc, siod_o, siod_oe;

  logic          q_end;
  logic [4:0]    nxt_bit;
  logic          ack_slot;

  assign q_end    = (cnt == CW'(CLK_DIV - 1));
  assign nxt_bit  = bit_idx + 5'd1;
  // The 9th bit of each phase is released so the sensor may drive it.
  assign ack_slot = (nxt_bit == 5'd8) || (nxt_bit == 5'd17) || (nxt_bit == 5'd26);

  assign bus.rom_addr = rom_addr;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.sioc     = sioc;
  assign bus.siod_o   = siod_o;
  assign bus.siod_oe  = siod_oe;

  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      qtr      <= '0;
      bit_idx  <= '0;
      frame    <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sioc     <= 1'b1;
      siod_o   <= 1'b1;
      siod_oe  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state    <= ST_FETCH;
            cnt      <= '0;
            rom_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= ST_CHECK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_CHECK: begin
          cnt <= '0;
          qtr <= '0;
          if (bus.rom_data == END_MARK) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`ifdef OV7670_SCCB_DELAY_EN
          else if (bus.rom_data == DELAY_MARK) begin
            state <= ST_DELAY;
          end
`endif
          else begin
            state   <= ST_START;
            frame   <= {WRITE_ID, 1'b1, bus.rom_data[15:8], 1'b1, bus.rom_data[7:0], 1'b1};
            sioc    <= 1'b1;
            siod_o  <= 1'b0;
            siod_oe <= 1'b1;
          end
        end
        ST_START: begin
          cnt <= q_end ? '0 : cnt + CW'(1);
          if (q_end) begin
            if (qtr == 2'd0) begin
              qtr  <= 2'd1;
              sioc <= 1'b0;
            end else begin
              state   <= ST_SEND;
              qtr     <= '0;
              bit_idx <= '0;
              siod_o  <= frame[26];
              siod_oe <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          cnt <= q_end ? '0 : cnt + CW'(1);
          if (q_end) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd1: sioc <= 1'b1;
              2'd3: begin
                sioc <= 1'b0;
                if (bit_idx == LAST_BIT) begin
                  state   <= ST_STOP;
                  siod_o  <= 1'b0;
                  siod_oe <= 1'b1;
                end else begin
                  bit_idx <= nxt_bit;
                  siod_o  <= frame[25];
                  frame   <= {frame[25:0], 1'b0};
                  siod_oe <= !ack_slot;
                end
              end
              default: ;
            endcase
          end
        end
        ST_STOP: begin
          cnt <= q_end ? '0 : cnt + CW'(1);
          if (q_end) begin
            case (qtr)
              2'd0: begin qtr <= 2'd1; sioc   <= 1'b1; end
              2'd1: begin qtr <= 2'd2; siod_o <= 1'b1; end
              default: begin qtr <= '0; state <= ST_GAP; end
            endcase
          end
        end
        ST_GAP: begin
          cnt <= q_end ? '0 : cnt + CW'(1);
          if (q_end) begin
            qtr <= qtr + 2'd1;
            if (qtr == 2'd3) begin
              if (rom_addr == 8'hFF) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                rom_addr <= rom_addr + 8'd1;
                state    <= ST_FETCH;
              end
            end
          end
        end
`ifdef OV7670_SCCB_DELAY_EN
        ST_DELAY: begin
          if (cnt == CW'(DELAY_CYCLES - 1)) begin
            cnt <= '0;
            if (rom_addr == 8'hFF) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rom_addr <= rom_addr + 8'd1;
              state    <= ST_FETCH;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Directed bench for ov7670_sccb_config: decodes SCCB frames off the pins and
// compares them with a scoreboard of expected {id,reg,val} words.
module tb_ov7670_sccb_config;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ov7670_sccb_config_if a_if ();
  ov7670_sccb_config_if b_if ();

  ov7670_sccb_config #(.CLK_DIV(4), .DELAY_CYCLES(100)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  ov7670_sccb_config #(.CLK_DIV(2), .DELAY_CYCLES(100)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  logic [15:0] rom_a [256];
  logic [15:0] rom_b [256];

  always @(posedge clk) begin
    a_if.rom_data <= rom_a[a_if.rom_addr];
    b_if.rom_data <= rom_b[b_if.rom_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  // Scoreboard and SCCB decoder for instance A.
  logic [23:0] exp_q [$];
  int          start_cyc [$];
  logic        p_sioc = 1'b1, p_siod = 1'b1;
  bit          in_frame = 1'b0, have_pend = 1'b0;
  logic        pend_v, pend_oe;
  logic [26:0] bits, oes;
  logic [23:0] want;
  int          nbits = 0, frames_a = 0, pulses_a = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      have_pend = 1'b0;
    end else if (p_sioc && a_if.sioc && p_siod && !a_if.siod_o) begin
      in_frame  = 1'b1;
      have_pend = 1'b0;
      nbits     = 0;
      bits      = '0;
      oes       = '0;
      start_cyc.push_back(cyc);
    end else if (p_sioc && a_if.sioc && !p_siod && a_if.siod_o && in_frame) begin
      in_frame = 1'b0;
      frames_a++;
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("frame_bytes", 32'({bits[26:19], bits[17:10], bits[8:1]}), 32'(want));
      end
      check("frame_bits", 32'(nbits), 32'd27);
      check("oe_mask", 32'(oes), 32'(27'b111111110_111111110_111111110));
    end else if (in_frame && !p_sioc && a_if.sioc) begin
      pend_v    = a_if.siod_o;
      pend_oe   = a_if.siod_oe;
      have_pend = 1'b1;
    end else if (in_frame && p_sioc && !a_if.sioc && have_pend) begin
      // A bit counts once its clock pulse completes; the stop's rising edge never falls.
      bits      = {bits[25:0], pend_v};
      oes       = {oes[25:0], pend_oe};
      nbits++;
      pulses_a++;
      have_pend = 1'b0;
    end
    p_sioc = a_if.sioc;
    p_siod = a_if.siod_o;
  end

  // Instance B only needs its frames counted.
  logic pb_sioc = 1'b1, pb_siod = 1'b1;
  int   frames_b = 0;
  always @(negedge clk) begin
    if (rst_n && pb_sioc && b_if.sioc && pb_siod && !b_if.siod_o) frames_b++;
    pb_sioc = b_if.sioc;
    pb_siod = b_if.siod_o;
  end

  // NOTE: stimulus uses blocking assignments on the falling edge, away from the sampling edge.
  task automatic pulse_start_a(output int t0);
    @(negedge clk) a_if.start = 1'b1;
    @(negedge clk) a_if.start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done_a(input int t0, input int limit, output int lat);
    while (!a_if.done && (cyc - t0) < limit) @(negedge clk);
    lat = cyc - t0;
  endtask

  task automatic clear_a();
    frames_a = 0;
    pulses_a = 0;
    start_cyc.delete();
  endtask

  int t0, lat;

  initial begin
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = 16'hFFFF;
      rom_b[i] = {i[7:0], ~i[7:0]};
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sioc",     32'(a_if.sioc),     32'd1);
    check("rst_siod_o",   32'(a_if.siod_o),   32'd1);
    check("rst_siod_oe",  32'(a_if.siod_oe),  32'd1);
    check("rst_busy",     32'(a_if.busy),     32'd0);
    check("rst_done",     32'(a_if.done),     32'd0);
    check("rst_rom_addr", 32'(a_if.rom_addr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single write then end marker.
    rom_a[0] = 16'h1280;
    rom_a[1] = 16'hFFFF;
    clear_a();
    exp_q.push_back(24'h421280);
    pulse_start_a(t0);
    check("busy_after_start", 32'(a_if.busy), 32'd1);
    wait_done_a(t0, 2000, lat);
    check("done_latency", 32'(lat), 32'd474);
    check("busy_at_done", 32'(a_if.busy), 32'd0);
    check("frames_single", 32'(frames_a), 32'd1);
    check("scl_pulses", 32'(pulses_a), 32'd27);
    check("start_seen", 32'(start_cyc.size()), 32'd1);
    if (start_cyc.size() != 0) check("first_start_cycle", 32'(start_cyc[0] - t0), 32'd3);
    check("sb_empty_single", 32'(exp_q.size()), 32'd0);
    check("idle_bus_done", 32'({a_if.sioc, a_if.siod_o, a_if.siod_oe}), 32'b111);
    check("end_addr_single", 32'(a_if.rom_addr), 32'd1);

    // Same table, extra start while busy must be ignored.
    clear_a();
    exp_q.push_back(24'h421280);
    pulse_start_a(t0);
    repeat (200) @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    wait_done_a(t0, 2000, lat);
    check("ignored_start_latency", 32'(lat), 32'd474);
    check("ignored_start_frames", 32'(frames_a), 32'd1);
    check("ignored_start_pulses", 32'(pulses_a), 32'd27);
    check("sb_empty_ignored", 32'(exp_q.size()), 32'd0);

    // Delay marker table.
    rom_a[0] = 16'h1280;
    rom_a[1] = 16'hFFF0;
    rom_a[2] = 16'h1100;
    rom_a[3] = 16'hFFFF;
    clear_a();
    exp_q.push_back(24'h421280);
`ifdef OV7670_SCCB_DELAY_EN
    exp_q.push_back(24'h421100);
`else
    exp_q.push_back(24'h42FFF0);
    exp_q.push_back(24'h421100);
`endif
    pulse_start_a(t0);
    wait_done_a(t0, 4000, lat);
`ifdef OV7670_SCCB_DELAY_EN
    check("delay_latency", 32'(lat), 32'd1048);
    check("delay_frames", 32'(frames_a), 32'd2);
    if (start_cyc.size() >= 2) check("delay_spacing", 32'(start_cyc[1] - start_cyc[0]), 32'd574);
`else
    check("nodelay_latency", 32'(lat), 32'd1416);
    check("nodelay_frames", 32'(frames_a), 32'd3);
    if (start_cyc.size() >= 2) check("nodelay_spacing", 32'(start_cyc[1] - start_cyc[0]), 32'd471);
`endif
    check("sb_empty_delay", 32'(exp_q.size()), 32'd0);
    check("end_addr_delay", 32'(a_if.rom_addr), 32'd3);

    // Reset in the middle of a frame.
    rom_a[0] = 16'h1280;
    rom_a[1] = 16'hFFFF;
    clear_a();
    exp_q.push_back(24'h421280);
    pulse_start_a(t0);
    repeat (100) @(negedge clk);
    check("busy_before_reset", 32'(a_if.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_sioc",    32'(a_if.sioc),    32'd1);
    check("abort_siod_o",  32'(a_if.siod_o),  32'd1);
    check("abort_siod_oe", 32'(a_if.siod_oe), 32'd1);
    check("abort_busy",    32'(a_if.busy),    32'd0);
    check("abort_done",    32'(a_if.done),    32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_a();
    exp_q.push_back(24'h421280);
    pulse_start_a(t0);
    wait_done_a(t0, 2000, lat);
    check("post_reset_latency", 32'(lat), 32'd474);
    check("post_reset_frames", 32'(frames_a), 32'd1);
    check("sb_empty_post_reset", 32'(exp_q.size()), 32'd0);

    // Full 256-entry table without an end marker on instance B.
    frames_b = 0;
    @(negedge clk) b_if.start = 1'b1;
    @(negedge clk) b_if.start = 1'b0;
    t0 = cyc;
    while (!b_if.done && (cyc - t0) < 256 * 237 + 200) @(negedge clk);
    check("full_table_latency", 32'(cyc - t0), 32'(256 * 237));
    check("full_table_frames", 32'(frames_b), 32'd256);
    check("full_table_busy", 32'(b_if.busy), 32'd0);
    repeat (20) @(negedge clk);
    check("full_table_done_held", 32'(b_if.done), 32'd1);
    check("full_table_addr_held", 32'(b_if.rom_addr), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
